// File: rtl/ysyx_25010008_mem_arbiter.sv
// Shares one AXI4-Lite-style memory slave between IFU reads and LSU reads/writes.
// Latency: 1 cycle from a request sampled in IDLE to the grant; granted channels pass through combinationally.
// Backpressure: the granted master sees the slave's ready/valid directly; the other master sees all zeros.
// Optional build macro YSYX_25010008_ARB_RR_EN selects round-robin instead of fixed LSU priority.
module ysyx_25010008_mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,

    input  logic [ADDR_W-1:0] ifu_araddr,
    input  logic              ifu_arvalid,
    output logic              ifu_arready,
    output logic [31:0]       ifu_rdata,
    output logic [1:0]        ifu_rresp,
    output logic              ifu_rvalid,
    input  logic              ifu_rready,

    input  logic [ADDR_W-1:0] lsu_araddr,
    input  logic              lsu_arvalid,
    output logic              lsu_arready,
    output logic [31:0]       lsu_rdata,
    output logic [1:0]        lsu_rresp,
    output logic              lsu_rvalid,
    input  logic              lsu_rready,
    input  logic [ADDR_W-1:0] lsu_awaddr,
    input  logic              lsu_awvalid,
    output logic              lsu_awready,
    input  logic [31:0]       lsu_wdata,
    input  logic [3:0]        lsu_wstrb,
    input  logic              lsu_wvalid,
    output logic              lsu_wready,
    output logic [1:0]        lsu_bresp,
    output logic              lsu_bvalid,
    input  logic              lsu_bready,

    output logic [ADDR_W-1:0] s_araddr,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic [31:0]       s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rvalid,
    output logic              s_rready,
    output logic [ADDR_W-1:0] s_awaddr,
    output logic              s_awvalid,
    input  logic              s_awready,
    output logic [31:0]       s_wdata,
    output logic [3:0]        s_wstrb,
    output logic              s_wvalid,
    input  logic              s_wready,
    input  logic [1:0]        s_bresp,
    input  logic              s_bvalid,
    output logic              s_bready
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        GRANT_IFU_R = 2'd1,
        GRANT_LSU_R = 2'd2,
        GRANT_LSU_W = 2'd3
    } state_t;

`ifdef YSYX_25010008_ARB_RR_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    state_t state;
    logic   last_grant;   // 0 = IFU held the last grant, 1 = LSU

    logic sel_ifu_r;
    logic sel_lsu_r;
    logic sel_lsu_w;
    logic lsu_req;
    logic ifu_wins;

    assign sel_ifu_r = (state == GRANT_IFU_R);
    assign sel_lsu_r = (state == GRANT_LSU_R);
    assign sel_lsu_w = (state == GRANT_LSU_W);

    // IFU wins when alone, or on a tie in round-robin mode when LSU had the previous grant.
    assign lsu_req  = lsu_arvalid | lsu_awvalid;
    assign ifu_wins = ifu_arvalid & (~lsu_req | (RR_EN & last_grant));

    // Grant FSM: pick one master in IDLE, release after the response handshake.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ifu_wins) begin
                        state      <= GRANT_IFU_R;
                        last_grant <= 1'b0;
                    end else if (lsu_awvalid) begin
                        // LSU writes go ahead of LSU reads so stores drain first.
                        state      <= GRANT_LSU_W;
                        last_grant <= 1'b1;
                    end else if (lsu_arvalid) begin
                        state      <= GRANT_LSU_R;
                        last_grant <= 1'b1;
                    end
                end
                GRANT_IFU_R: if (s_rvalid && ifu_rready) state <= IDLE;
                GRANT_LSU_R: if (s_rvalid && lsu_rready) state <= IDLE;
                GRANT_LSU_W: if (s_bvalid && lsu_bready) state <= IDLE;
                default:     state <= IDLE;
            endcase
        end
    end

    // Read-address path: only the read grant states open the AR channel.
    assign s_araddr    = sel_ifu_r ? ifu_araddr : lsu_araddr;
    assign s_arvalid   = (sel_ifu_r & ifu_arvalid) | (sel_lsu_r & lsu_arvalid);
    assign ifu_arready = sel_ifu_r & s_arready;
    assign lsu_arready = sel_lsu_r & s_arready;

    // Read-data path: data and response broadcast, valid steered to the owner.
    assign ifu_rdata  = s_rdata;
    assign ifu_rresp  = s_rresp;
    assign ifu_rvalid = sel_ifu_r & s_rvalid;
    assign lsu_rdata  = s_rdata;
    assign lsu_rresp  = s_rresp;
    assign lsu_rvalid = sel_lsu_r & s_rvalid;
    assign s_rready   = (sel_ifu_r & ifu_rready) | (sel_lsu_r & lsu_rready);

    // Write path: AW and W pass independently; their relative order is the slave's concern.
    assign s_awaddr    = lsu_awaddr;
    assign s_awvalid   = sel_lsu_w & lsu_awvalid;
    assign lsu_awready = sel_lsu_w & s_awready;
    assign s_wdata     = lsu_wdata;
    assign s_wstrb     = lsu_wstrb;
    assign s_wvalid    = sel_lsu_w & lsu_wvalid;
    assign lsu_wready  = sel_lsu_w & s_wready;
    assign lsu_bresp   = s_bresp;
    assign lsu_bvalid  = sel_lsu_w & s_bvalid;
    assign s_bready    = sel_lsu_w & lsu_bready;

endmodule

// File: tb/tb_ysyx_25010008_mem_arbiter.sv
// Directed bench for the memory arbiter: a slave model checks what reaches the slave side,
// a response monitor pops expected master-side responses, and the stimulus drives the masters.
// Slave read data is address ^ 0x9234_5678; expected values below are worked out by hand.
module tb_ysyx_25010008_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] ifu_araddr = '0;
    logic        ifu_arvalid = 1'b0;
    logic        ifu_arready;
    logic [31:0] ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        ifu_rvalid;
    logic        ifu_rready = 1'b1;
    logic [31:0] lsu_araddr = '0;
    logic        lsu_arvalid = 1'b0;
    logic        lsu_arready;
    logic [31:0] lsu_rdata;
    logic [1:0]  lsu_rresp;
    logic        lsu_rvalid;
    logic        lsu_rready = 1'b1;
    logic [31:0] lsu_awaddr = '0;
    logic        lsu_awvalid = 1'b0;
    logic        lsu_awready;
    logic [31:0] lsu_wdata = '0;
    logic [3:0]  lsu_wstrb = '0;
    logic        lsu_wvalid = 1'b0;
    logic        lsu_wready;
    logic [1:0]  lsu_bresp;
    logic        lsu_bvalid;
    logic        lsu_bready = 1'b1;
    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;
    logic [31:0] s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;

    ysyx_25010008_mem_arbiter #(.ADDR_W(32)) dut (
        .clock(clock), .reset(reset),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
        .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
    );

    always #5 clock = ~clock;

    // Every handshake-bearing output; all zero whenever the arbiter sits in IDLE or reset.
    logic [11:0] bus_act;
    assign bus_act = {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready, ifu_arready,
                      lsu_arready, lsu_awready, lsu_wready, ifu_rvalid, lsu_rvalid, lsu_bvalid};

    typedef struct {
        int          id;    // 0 IFU read, 1 LSU read, 2 LSU write response
        logic [31:0] data;
        logic [1:0]  resp;
    } rsp_t;

    rsp_t        exp_rsp[$];
    logic [31:0] exp_ar[$];
    logic [31:0] exp_aw[$];
    logic [35:0] exp_w[$];

    int checks   = 0;
    int failures = 0;

    // Slave configuration, written by stimulus, read by the slave model.
    int          sl_delay = 3;
    logic [1:0]  sl_rresp = 2'b00;
    logic [1:0]  sl_bresp = 2'b00;
    logic        sl_flush = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        checks++;
        failures++;
        $display("FAIL %s: unexpected transfer %0h, nothing expected", name, act);
    endtask

    // Slave model: accepts AR/AW/W, returns R after sl_delay cycles and B once AW and W arrived.
    initial begin
        logic        ar_hs, r_hs, aw_hs, w_hs, b_hs;
        logic        rd_busy, aw_got, w_got;
        logic [31:0] rd_addr;
        int          rd_cnt;
        rd_busy = 1'b0; aw_got = 1'b0; w_got = 1'b0; rd_addr = '0; rd_cnt = 0;
        s_arready = 1'b1; s_rdata = '0; s_rresp = 2'b00; s_rvalid = 1'b0;
        s_awready = 1'b1; s_wready = 1'b1; s_bresp = 2'b00; s_bvalid = 1'b0;
        forever begin
            @(negedge clock);
            ar_hs = s_arvalid && s_arready;
            r_hs  = s_rvalid && s_rready;
            aw_hs = s_awvalid && s_awready;
            w_hs  = s_wvalid && s_wready;
            b_hs  = s_bvalid && s_bready;
            if (ar_hs) begin
                rd_addr = s_araddr;
                if (exp_ar.size() == 0) unexpected("slave_ar", {32'h0, s_araddr});
                else chk("slave_araddr", {32'h0, s_araddr}, {32'h0, exp_ar.pop_front()});
            end
            if (aw_hs) begin
                if (exp_aw.size() == 0) unexpected("slave_aw", {32'h0, s_awaddr});
                else chk("slave_awaddr", {32'h0, s_awaddr}, {32'h0, exp_aw.pop_front()});
            end
            if (w_hs) begin
                if (exp_w.size() == 0) unexpected("slave_w", {28'h0, s_wstrb, s_wdata});
                else chk("slave_wstrb_wdata", {28'h0, s_wstrb, s_wdata}, {28'h0, exp_w.pop_front()});
            end
            @(posedge clock);
            #3;
            if (sl_flush) begin
                rd_busy = 1'b0; aw_got = 1'b0; w_got = 1'b0;
                s_arready = 1'b1; s_rvalid = 1'b0; s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b0;
            end else begin
                if (r_hs) begin
                    s_rvalid = 1'b0; rd_busy = 1'b0; s_arready = 1'b1;
                end
                if (ar_hs) begin
                    rd_busy = 1'b1; rd_cnt = sl_delay; s_arready = 1'b0;
                end else if (rd_busy && !s_rvalid) begin
                    if (rd_cnt <= 1) begin
                        s_rvalid = 1'b1;
                        s_rdata  = rd_addr ^ 32'h9234_5678;
                        s_rresp  = sl_rresp;
                    end else begin
                        rd_cnt--;
                    end
                end
                if (b_hs) begin
                    s_bvalid = 1'b0; aw_got = 1'b0; w_got = 1'b0; s_awready = 1'b1; s_wready = 1'b1;
                end
                if (aw_hs) begin aw_got = 1'b1; s_awready = 1'b0; end
                if (w_hs)  begin w_got = 1'b1;  s_wready = 1'b0;  end
                if (aw_got && w_got && !s_bvalid && !b_hs) begin
                    s_bvalid = 1'b1;
                    s_bresp  = sl_bresp;
                end
            end
        end
    end

    task automatic check_rsp(input int id, input logic [31:0] data, input logic [1:0] resp);
        rsp_t e;
        if (exp_rsp.size() == 0) begin
            unexpected("master_rsp", {id[31:0], data});
        end else begin
            e = exp_rsp.pop_front();
            chk("rsp_owner", 64'(id), 64'(e.id));
            chk("rsp_data", {32'h0, data}, {32'h0, e.data});
            chk("rsp_resp", {62'h0, resp}, {62'h0, e.resp});
        end
    endtask

    // Response monitor: pops the scoreboard on every master-side response and
    // checks that the cycle after each completion is an IDLE cycle.
    initial begin
        logic done_prev;
        done_prev = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                done_prev = 1'b0;
            end else begin
                if (done_prev) chk("idle_after_completion", {52'h0, bus_act}, 64'h0);
                done_prev = 1'b0;
                if (ifu_rvalid && ifu_rready) begin check_rsp(0, ifu_rdata, ifu_rresp); done_prev = 1'b1; end
                if (lsu_rvalid && lsu_rready) begin check_rsp(1, lsu_rdata, lsu_rresp); done_prev = 1'b1; end
                if (lsu_bvalid && lsu_bready) begin check_rsp(2, 32'h0, lsu_bresp);     done_prev = 1'b1; end
            end
        end
    end

    // One clock of master-side driving: snapshot at the falling edge, drop
    // address/data valids that handshook, return just after the rising edge.
    logic [11:0] snap_act;
    logic [31:0] snap_araddr;
    task automatic step();
        logic h_ifu_ar, h_lsu_ar, h_lsu_aw, h_lsu_w;
        @(negedge clock);
        snap_act    = bus_act;
        snap_araddr = s_araddr;
        h_ifu_ar = ifu_arvalid && ifu_arready;
        h_lsu_ar = lsu_arvalid && lsu_arready;
        h_lsu_aw = lsu_awvalid && lsu_awready;
        h_lsu_w  = lsu_wvalid && lsu_wready;
        @(posedge clock);
        #1;
        if (h_ifu_ar) ifu_arvalid = 1'b0;
        if (h_lsu_ar) lsu_arvalid = 1'b0;
        if (h_lsu_aw) lsu_awvalid = 1'b0;
        if (h_lsu_w)  lsu_wvalid  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while ((exp_rsp.size() != 0 || ifu_arvalid || lsu_arvalid || lsu_awvalid || lsu_wvalid) && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (n >= 200) begin
            failures++;
            $display("FAIL %s: transaction still pending after %0d cycles, required completion", tag, n);
        end
        step();
        step();
    endtask

    task automatic push_rsp(input int id, input logic [31:0] data, input logic [1:0] resp);
        rsp_t e;
        e.id = id; e.data = data; e.resp = resp;
        exp_rsp.push_back(e);
    endtask

    initial begin
        int hits;

        // Reset with requests pending: nothing may leak out.
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0000;
        lsu_arvalid = 1'b1; lsu_araddr = 32'h0000_0010;
        step();
        chk("reset_outputs_zero", {52'h0, snap_act}, 64'h0);
        ifu_arvalid = 1'b0; lsu_arvalid = 1'b0;
        step();
        reset = 1'b1;
        hits = 0;
        repeat (3) begin step(); if (snap_act != 12'h0) hits++; end
        chk("no_grant_without_request", 64'(hits), 64'h0);

        // IFU-only read with 1-cycle arbitration latency.
        ifu_araddr = 32'h8000_0000; ifu_arvalid = 1'b1;
        exp_ar.push_back(32'h8000_0000);
        push_rsp(0, 32'h1234_5678, 2'b00);
        step();
        chk("arb_latency_idle_cycle", {63'h0, snap_act[11]}, 64'h0);
        step();
        chk("arb_latency_grant", {31'h0, snap_act[11], snap_araddr}, {31'h0, 1'b1, 32'h8000_0000});
        wait_done("ifu_read");

        // LSU write, OKAY response.
        lsu_awaddr = 32'hA000_03F8; lsu_awvalid = 1'b1;
        lsu_wdata = 32'h0000_0041; lsu_wstrb = 4'b0001; lsu_wvalid = 1'b1;
        exp_aw.push_back(32'hA000_03F8);
        exp_w.push_back({4'b0001, 32'h0000_0041});
        push_rsp(2, 32'h0, 2'b00);
        wait_done("lsu_write");

        // LSU write and read together: write first; write carries an EXOKAY response.
        sl_bresp = 2'b01;
        lsu_awaddr = 32'h0000_0080; lsu_awvalid = 1'b1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'b1111; lsu_wvalid = 1'b1;
        lsu_araddr = 32'h0000_0020; lsu_arvalid = 1'b1;
        exp_aw.push_back(32'h0000_0080);
        exp_w.push_back({4'b1111, 32'hDEAD_BEEF});
        push_rsp(2, 32'h0, 2'b01);
        exp_ar.push_back(32'h0000_0020);
        push_rsp(1, 32'h9234_5658, 2'b00);
        wait_done("lsu_write_then_read");
        sl_bresp = 2'b00;

        // IFU and LSU reads together; last grant was LSU.
        ifu_araddr = 32'h8000_0004; ifu_arvalid = 1'b1;
        lsu_araddr = 32'h0000_0040; lsu_arvalid = 1'b1;
`ifdef YSYX_25010008_ARB_RR_EN
        exp_ar.push_back(32'h8000_0004);
        push_rsp(0, 32'h1234_567C, 2'b00);
        exp_ar.push_back(32'h0000_0040);
        push_rsp(1, 32'h9234_5638, 2'b00);
`else
        exp_ar.push_back(32'h0000_0040);
        push_rsp(1, 32'h9234_5638, 2'b00);
        exp_ar.push_back(32'h8000_0004);
        push_rsp(0, 32'h1234_567C, 2'b00);
`endif
        wait_done("simultaneous_reads");

        // IFU read answered with SLVERR.
        sl_rresp = 2'b10;
        ifu_araddr = 32'h8000_0008; ifu_arvalid = 1'b1;
        exp_ar.push_back(32'h8000_0008);
        push_rsp(0, 32'h1234_5670, 2'b10);
        wait_done("ifu_read_slverr");
        sl_rresp = 2'b00;

        // Reset in the middle of an LSU read, before the slave answers.
        sl_delay = 6;
        lsu_araddr = 32'h0000_0100; lsu_arvalid = 1'b1;
        exp_ar.push_back(32'h0000_0100);
        step();
        step();
        step();
        chk("pre_reset_lsu_read_granted", {62'h0, snap_act[8], snap_act[2]}, {62'h0, 2'b10});
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_outputs_zero", {52'h0, bus_act}, 64'h0);
        step();
        step();
        reset = 1'b1;
        hits = 0;
        repeat (12) begin step(); if (snap_act[2] || snap_act[1]) hits++; end
        chk("no_rvalid_after_reset", 64'(hits), 64'h0);
        sl_flush = 1'b1;
        step();
        sl_flush = 1'b0;
        sl_delay = 3;
        step();
        step();

        chk("scoreboard_drained", 64'(exp_rsp.size() + exp_ar.size() + exp_aw.size() + exp_w.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_25010008_mem_arbiter.md
YSYX_25010008_MEM_ARBITER -- requirements
Module: ysyx_25010008_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width of all AR/AW channels.
REQ-002 SHALL have ports: clock  input  1  single clock, all state on rising edge.
REQ-003 SHALL have ports: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: ifu_araddr/arvalid/arready  in/in/out  ADDR_W/1/1  IFU read-address channel.
REQ-005 SHALL have ports: ifu_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  IFU read-data channel.
REQ-006 SHALL have ports: lsu_araddr/arvalid/arready  in/in/out  ADDR_W/1/1  LSU read-address channel.
REQ-007 SHALL have ports: lsu_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  LSU read-data channel.
REQ-008 SHALL have ports: lsu_awaddr/awvalid/awready, lsu_wdata/wstrb/wvalid/wready  in/in/out, in/in/in/out  ADDR_W/1/1, 32/4/1/1  LSU write address and data channels.
REQ-009 SHALL have ports: lsu_bresp/bvalid/bready  out/out/in  2/1/1  LSU write-response channel.
REQ-010 SHALL have ports: s_* mirror of all five channels (AR, R, AW, W, B), opposite direction, same widths, toward the single memory slave.

Function
REQ-011 SHALL implement states IDLE, GRANT_IFU_R, GRANT_LSU_R, GRANT_LSU_W, encoded in a 2-bit register.
REQ-012 SHALL, in IDLE, sample requests: ifu_arvalid, lsu_arvalid, lsu_awvalid; all master ready/valid outputs and all s_* valids driven 0.
REQ-013 SHALL transition IDLE->grant state one cycle after a request is sampled; arbitration latency exactly 1 cycle.
REQ-014 SHALL, within LSU, prefer write over read when lsu_awvalid and lsu_arvalid are both high.
REQ-015 SHALL, while granted, connect the granted master's channels combinationally to s_* (zero added latency); non-granted master sees arready/awready/wready/rvalid/bvalid = 0.
REQ-016 SHALL forward AW and W independently in GRANT_LSU_W; arbiter does not order them.
REQ-017 SHALL hold a read grant until s_rvalid && granted rready in the same cycle, then return to IDLE next cycle.
REQ-018 SHALL hold a write grant until s_bvalid && lsu_bready in the same cycle, then return to IDLE next cycle.
REQ-019 SHALL pass rresp/bresp unmodified; error responses do not alter state sequencing.
REQ-020 SHALL not re-grant in the completion cycle; minimum one IDLE cycle between transactions.
REQ-021 SHALL keep a 1-bit last_grant register (0=IFU, 1=LSU) updated on every grant.
REQ-022 SHALL ignore requests that deassert before grant (no grant issued if no valid in IDLE).

Reset
REQ-023 SHALL, on reset low, immediately force state=IDLE, last_grant=0, all valid/ready outputs 0, regardless of clock.
REQ-024 SHALL, on reset mid-transaction, abandon the in-flight transaction; no response forwarded after reset release.
REQ-025 SHALL leave data/address outputs don't-care while the associated valid is 0.

Configuration
REQ-026 SHALL support macro YSYX_25010008_ARB_RR_EN.
REQ-027 SHALL, with YSYX_25010008_ARB_RR_EN defined, on simultaneous IFU and LSU requests grant the master not equal to last_grant (round-robin).
REQ-028 SHALL, without YSYX_25010008_ARB_RR_EN, always grant LSU on simultaneous requests (fixed priority); last_grant still maintained.

Verification
REQ-029 SHALL cover: IFU-only read 0x8000_0000, slave rdata 0x1234_5678 after 3 cycles -> ifu_rvalid with 0x1234_5678, lsu sees nothing, IDLE after handshake.
REQ-030 SHALL cover: simultaneous IFU and LSU read, fixed priority -> LSU granted first, IFU granted after one IDLE cycle; with RR and last_grant=1 -> IFU first.
REQ-031 SHALL cover: LSU write 0xA000_03F8, wdata 0x41, wstrb 4'b0001, slave bresp 2'b00 -> s_awaddr/s_wstrb match, lsu_bvalid asserted once, IDLE next cycle.
REQ-032 SHALL cover: LSU awvalid and arvalid together -> write granted first, read second.
REQ-033 SHALL cover: reset asserted during GRANT_LSU_R before s_rvalid -> all outputs 0 asynchronously, no lsu_rvalid after release.
REQ-034 SHALL cover: slave rresp 2'b10 on IFU read -> ifu_rresp 2'b10, normal return to IDLE.
